// File: rtl/ld_cell_a2d_intf.sv
// ld_cell_a2d_intf: SPI master sweeping left/right load cells and battery on an ADC128S-style A2D.
// Define LD_FILT_EN to IIR-filter lft_ld/rght_ld as (3*old + sample) >> 2.
module ld_cell_a2d_intf #(
    parameter logic [2:0] LFT_CHNL  = 3'd0,
    parameter logic [2:0] RGHT_CHNL = 3'd4,
    parameter logic [2:0] BATT_CHNL = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        busy,
    output logic        vld
);
    typedef enum logic [2:0] {IDLE, CMD, GAP1, READ, GAP2, DONE} state_t;
    state_t      state;
    logic [2:0]  chnl, nxt_chnl, start_chnl;
    logic        gap, start, frm_end;
    logic [4:0]  div, cnt;
    logic [15:0] tx;
    logic [11:0] rx, lft_next, rght_next;
    always_comb begin
        SCLK       = div[4];
        MOSI       = tx[15];
        frm_end    = !SS_n && cnt == 5'd16 && div == 5'd30;
        nxt_chnl   = (chnl == LFT_CHNL) ? RGHT_CHNL : BATT_CHNL;
        start      = (state == IDLE && nxt) || (state == GAP1 && gap) ||
                     (state == GAP2 && gap && chnl != BATT_CHNL);
        start_chnl = (state == IDLE) ? LFT_CHNL : (state == GAP2) ? nxt_chnl : chnl;
    end
    // The first falling SCLK edge precedes any rising edge, so it must not shift tx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n <= 1'b1;
            div  <= 5'h1f;
            cnt  <= 5'd0;
            tx   <= 16'h0000;
            rx   <= 12'h000;
        end else if (start) begin
            SS_n <= 1'b0;
            div  <= 5'b10111;
            cnt  <= 5'd0;
            tx   <= {2'b00, start_chnl, 11'h000};
        end else if (!SS_n) begin
            div <= div + 5'd1;
            if (div == 5'b01111) begin
                rx  <= {rx[10:0], MISO};
                cnt <= cnt + 5'd1;
            end
            if (div == 5'b11111 && cnt != 5'd0)
                tx <= {tx[14:0], 1'b0};
            if (frm_end)
                SS_n <= 1'b1;
        end
    end
`ifdef LD_FILT_EN
    logic primed;
    always_comb begin
        lft_next  = primed ? 12'(({2'b00, lft_ld} * 14'd3 + {2'b00, rx}) >> 2) : rx;
        rght_next = primed ? 12'(({2'b00, rght_ld} * 14'd3 + {2'b00, rx}) >> 2) : rx;
    end
`else
    always_comb begin
        lft_next  = rx;
        rght_next = rx;
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            chnl    <= LFT_CHNL;
            gap     <= 1'b0;
            busy    <= 1'b0;
            vld     <= 1'b0;
            lft_ld  <= 12'h000;
            rght_ld <= 12'h000;
            batt    <= 12'h000;
`ifdef LD_FILT_EN
            primed  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (nxt) begin
                    chnl  <= LFT_CHNL;
                    busy  <= 1'b1;
                    state <= CMD;
                end
                CMD: if (frm_end) begin
                    gap   <= 1'b0;
                    state <= GAP1;
                end
                GAP1: begin
                    gap <= 1'b1;
                    if (gap) state <= READ;
                end
                READ: if (frm_end) begin
                    if (chnl == LFT_CHNL) lft_ld <= lft_next;
                    else if (chnl == RGHT_CHNL) rght_ld <= rght_next;
                    else batt <= rx;
                    gap   <= 1'b0;
                    state <= GAP2;
                end
                GAP2: begin
                    gap <= 1'b1;
                    if (gap && chnl == BATT_CHNL) begin
                        vld   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (gap) begin
                        chnl  <= nxt_chnl;
                        state <= CMD;
                    end
                end
                default: begin
                    vld   <= 1'b0;
`ifdef LD_FILT_EN
                    primed <= 1'b1;
`endif
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
